// File: rtl/mips_cpu_muldiv_seq.sv
// HI/LO owner and multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, plus pipeline stall.
module mips_cpu_muldiv_seq #(
  parameter bit          MUL_FAST = 1'b0,
  parameter logic [31:0] DIV0_LO  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] OP_MULT  = 5'd2;
  localparam logic [4:0] OP_MULTU = 5'd22;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd23;
  localparam logic [4:0] OP_MTHI  = 5'd24;
  localparam logic [4:0] OP_MTLO  = 5'd25;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [63:0] acc_reg;     // multiply: {partial, multiplier}; divide: [31:0] dividend/quotient
  logic [31:0] rem_reg;
  logic [31:0] mb_reg;      // multiplicand or divisor magnitude
  logic [31:0] a_reg;
  logic        div_reg, b_zero_reg, neg_q_reg, neg_r_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        is_mul, is_div, signed_op, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_mag, prod;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sa        = signed_op & a[31];
    sb        = signed_op & b[31];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
  end

  // One iteration of each algorithm; the shifted remainder never exceeds 33 bits.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? mb_reg : 32'd0)};
    div_shift = {rem_reg, acc_reg[31]};
    div_diff  = div_shift - {1'b0, mb_reg};
  end

  always_comb begin
    prod_mag = MUL_FAST ? ({32'd0, mb_reg} * {32'd0, acc_reg[31:0]}) : acc_reg;
    prod     = neg_q_reg ? -prod_mag : prod_mag;
    fix_hi   = prod[63:32];
    fix_lo   = prod[31:0];
    if (div_reg) begin
      if (b_zero_reg) begin
        fix_hi = a_reg;
        fix_lo = DIV0_LO;
      end else begin
        fix_hi = neg_r_reg ? -rem_reg : rem_reg;
        fix_lo = neg_q_reg ? -acc_reg[31:0] : acc_reg[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && (is_mul || is_div))
                 state_next = (MUL_FAST && is_mul) ? FIXUP : CALC;
      CALC:    if (cnt_reg == 5'd31) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    stall = busy & (hilo_rd | start);
    done  = done_reg;
    hi    = hi_reg;
    lo    = lo_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      mb_reg     <= '0;
      a_reg      <= '0;
      div_reg    <= 1'b0;
      b_zero_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          if (op == OP_MTHI) begin
            hi_reg <= a;
          end else if (op == OP_MTLO) begin
            lo_reg <= a;
          end else if (is_mul || is_div) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            a_reg      <= a;
            div_reg    <= is_div;
            b_zero_reg <= (b == 32'd0);
            neg_q_reg  <= sa ^ sb;
            neg_r_reg  <= sa;
            mb_reg     <= is_div ? mag_b : mag_a;
            acc_reg    <= {32'd0, (is_div ? mag_a : mag_b)};
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (div_reg) begin
            rem_reg        <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            acc_reg[31:0]  <= {acc_reg[30:0], ~div_diff[32]};
          end else begin
            acc_reg <= {mul_sum, acc_reg[31:1]};
          end
        end
        FIXUP: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed-vector bench for mips_cpu_muldiv_seq: iterative and fast-multiply instances.
module tb_mips_cpu_muldiv_seq;

  localparam logic [4:0] OP_MULT  = 5'd2;
  localparam logic [4:0] OP_MULTU = 5'd22;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd23;
  localparam logic [4:0] OP_MTLO  = 5'd25;

  logic        clk, reset_n, start, start_f, hilo_rd;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall, busy_f, done_f, stall_f;
  logic [31:0] hi, lo, hi_f, lo_f;

  int n_checks = 0;
  int n_pass   = 0;

  mips_cpu_muldiv_seq #(.MUL_FAST(1'b0), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  mips_cpu_muldiv_seq #(.MUL_FAST(1'b1), .DIV0_LO(32'hFFFF_FFFF)) dut_fast (
    .clk(clk), .reset_n(reset_n), .start(start_f), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .busy(busy_f), .done(done_f), .stall(stall_f), .hi(hi_f), .lo(lo_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one arithmetic op, wait for done, check latency, results and single done pulse.
  task automatic run_op(input bit fast, input string tag, input logic [4:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    int cyc;
    @(negedge clk);
    op = o; a = av; b = bv;
    if (fast) start_f = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_f = 1'b0;
    check({tag, "_busy"}, fast ? busy_f : busy, 1);
    cyc = 0;
    while (!(fast ? done_f : done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_hi"}, fast ? hi_f : hi, exp_hi);
    check({tag, "_lo"}, fast ? lo_f : lo, exp_lo);
    @(negedge clk);
    check({tag, "_done_once"}, fast ? done_f : done, 0);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", tag, o, av, bv,
             fast ? hi_f : hi, fast ? lo_f : lo, cyc);
  endtask

  initial begin
    int cyc, stall_miss;
    reset_n = 1'b0; start = 1'b0; start_f = 1'b0; hilo_rd = 1'b0;
    op = '0; a = '0; b = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(1'b0, "mult_neg3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
    run_op(1'b0, "multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op(1'b1, "fast_multu_max",OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    run_op(1'b1, "fast_mult_neg", OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
    run_op(1'b0, "div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op(1'b0, "divu_100by7",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33);
    run_op(1'b0, "divu_by0",      OP_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33);
    run_op(1'b0, "div_min_by_m1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33);

    // Stall on MFHI/MFLO and on a held second op while the divide is running.
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hilo_rd = 1'b1;
    #1 check("stall_hilo_rd", stall, 1);
    @(negedge clk);
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    #1 check("stall_second_start", stall, 1);
    stall_miss = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (busy && !stall) stall_miss++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check("stall_held_all_busy", stall_miss, 0);
    check("stall_done_seen", done, 1);
    check("stall_on_done_cycle", stall, 0);
    check("stall_div_hi", hi, 32'd1);
    check("stall_div_lo", lo, 32'd333);
    $display("txn stall_divu a=1000 b=3 -> hi=%h lo=%h", hi, lo);
    hilo_rd = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("held_multu_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("held_multu_latency", cyc, 33);
    check("held_multu_hi", hi, 32'd0);
    check("held_multu_lo", lo, 32'd12);
    $display("txn held_multu a=3 b=4 -> hi=%h lo=%h", hi, lo);

    // MTLO while idle: immediate write, no stall, no done.
    @(negedge clk);
    op = OP_MTLO; a = 32'hA5A5_A5A5; start = 1'b1;
    #1 check("mtlo_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'hA5A5_A5A5);
    check("mtlo_hi_kept", hi, 32'd0);
    check("mtlo_no_done", done, 0);
    $display("txn mtlo a=a5a5a5a5 -> lo=%h", lo);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op = OP_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    $display("txn reset_mid_calc -> busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, "multu_3x4_after_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
